// File: rtl/ula_sequencial_pkg.sv
// Shared definitions for the sequential ALU slice.
// Contents: ISA opcode map, FSM state type, and a helper that flags the
// opcodes executed by the iterative multiply/divide engine.
package ula_pkg;

    localparam logic [4:0] OP_MOV  = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_SUB  = 5'b00101;
    localparam logic [4:0] OP_MUL  = 5'b00110;
    localparam logic [4:0] OP_DIV  = 5'b00111;
    localparam logic [4:0] OP_AND  = 5'b01000;
    localparam logic [4:0] OP_NAND = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_XOR  = 5'b01011;
    localparam logic [4:0] OP_CMP  = 5'b01100;
    localparam logic [4:0] OP_NOT  = 5'b01101;
    localparam logic [4:0] OP_BEQ  = 5'b01111;
    localparam logic [4:0] OP_BGT  = 5'b10000;
    localparam logic [4:0] OP_BLT  = 5'b10001;
    localparam logic [4:0] OP_BGE  = 5'b10010;
    localparam logic [4:0] OP_BLE  = 5'b10011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } ula_estado_t;

    function automatic logic is_iterativo(input logic [4:0] opcode);
        return (opcode == OP_MUL) || (opcode == OP_DIV);
    endfunction

endpackage

// File: rtl/ula_sequencial_if.sv
// Handshake bundle between the control unit (master) and the ALU (slave).
//   in_valid/in_ready   : request handshake, opcode + operands ride with it
//   out_valid/out_ready : result handshake, resultado/data_uc/div_zero ride with it
interface ula_sequencial_if #(
    parameter int unsigned WIDTH = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [4:0]             opcode;
    logic [WIDTH-1:0]       operando1;
    logic [WIDTH-1:0]       operando2;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     resultado;
    logic                   data_uc;
    logic                   div_zero;

    modport master (
        output in_valid, opcode, operando1, operando2, out_ready,
        input  in_ready, out_valid, resultado, data_uc, div_zero
    );

    modport slave (
        input  in_valid, opcode, operando1, operando2, out_ready,
        output in_ready, out_valid, resultado, data_uc, div_zero
    );
endinterface

// File: rtl/ula_sequencial_mul_div.sv
// Iterative multiply/divide engine, one step per cycle, WIDTH steps.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   start_i        : load operands and begin (is_div_i selects divide)
//   op_a_i, op_b_i : multiplicand/multiplier or dividend/divisor
//   done_o         : high in the cycle whose edge performs the last step
//   produto_o      : 2*WIDTH product; quociente_o/resto_o : divide results
// hi/lo/b registers are shared: MUL uses {hi,lo} as the right-shifting
// partial product (lo starts as multiplier), DIV uses hi as remainder and
// lo as dividend shifting out / quotient shifting in.
module ula_mul_div #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               is_div_i,
    input  logic [WIDTH-1:0]   op_a_i,
    input  logic [WIDTH-1:0]   op_b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] produto_o,
    output logic [WIDTH-1:0]   quociente_o,
    output logic [WIDTH-1:0]   resto_o
);
    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d, is_div_q;
    logic [WIDTH:0]   soma, desloc, tentativa;

    assign soma      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign desloc    = {hi_q, lo_q[WIDTH-1]};
    assign tentativa = desloc - {1'b0, b_q};

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            hi_d   = '0;
            lo_d   = op_a_i;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == ULTIMO) begin
                busy_d = 1'b0;
            end
            if (is_div_q) begin
                // Borrow out of the trial subtraction means "restore".
                if (!tentativa[WIDTH]) begin
                    hi_d = tentativa[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = desloc[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                {hi_d, lo_d} = {soma, lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            is_div_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            if (start_i) begin
                b_q      <= op_b_i;
                is_div_q <= is_div_i;
            end
        end
    end

    assign done_o      = busy_q && (cnt_q == ULTIMO);
    assign produto_o   = {hi_q, lo_q};
    assign quociente_o = lo_q;
    assign resto_o     = hi_q;

endmodule

// File: rtl/ula_sequencial.sv
// Multi-cycle ALU with valid/ready handshakes on request and result.
//   clock, reset : clock, synchronous active-high reset
//   bus (slave)  : in_valid/in_ready/opcode/operando1/operando2 request,
//                  out_valid/out_ready/resultado/data_uc/div_zero result
// The FSM enters DONE on the accept edge (or the last engine step); the
// result registers and out_valid are written on the first edge spent in
// DONE, which gives the one-cycle / WIDTH+1-cycle result latency.
module ula_sequencial
    import ula_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    ula_sequencial_if.slave  bus
);
    ula_estado_t        state_q, state_d;
    logic [4:0]         opcode_q;
    logic [WIDTH-1:0]   op1_q, op2_q;
    logic               out_valid_q;
    logic [2*WIDTH-1:0] resultado_q, resultado_d;
    logic               data_uc_q, data_uc_d, div_zero_q, div_zero_d;

    logic               accept, div_zero_in, eng_start, eng_done, captura;
    logic [2*WIDTH-1:0] eng_produto;
    logic [WIDTH-1:0]   eng_quo, eng_resto;
    logic [WIDTH:0]     soma, dif;
    logic               neg1, zero1, a_maior, a_menor;

    assign accept      = bus.in_valid && (state_q == ST_IDLE);
    assign div_zero_in = (bus.opcode == OP_DIV) && (bus.operando2 == '0);
    assign eng_start   = accept && is_iterativo(bus.opcode) && !div_zero_in;
    assign captura     = (state_q == ST_DONE) && !out_valid_q;

    ula_mul_div #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul_div (
        .clk_i       (clock),
        .rst_i       (reset),
        .start_i     (eng_start),
        .is_div_i    (bus.opcode == OP_DIV),
        .op_a_i      (bus.operando1),
        .op_b_i      (bus.operando2),
        .done_o      (eng_done),
        .produto_o   (eng_produto),
        .quociente_o (eng_quo),
        .resto_o     (eng_resto)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                state_d = (is_iterativo(bus.opcode) && !div_zero_in) ? ST_ITER : ST_DONE;
            end
            ST_ITER: if (eng_done) state_d = ST_DONE;
            ST_DONE: if (out_valid_q && bus.out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign soma    = {1'b0, op1_q} + {1'b0, op2_q};
    assign dif     = {1'b0, op1_q} - {1'b0, op2_q};
    assign neg1    = op1_q[WIDTH-1];
    assign zero1   = (op1_q == '0);
    assign a_maior = $signed(op1_q) > $signed(op2_q);
    assign a_menor = $signed(op1_q) < $signed(op2_q);

    always_comb begin
        resultado_d = '0;
        data_uc_d   = 1'b0;
        div_zero_d  = 1'b0;
        case (opcode_q)
            OP_MOV:  resultado_d = {{WIDTH{1'b0}}, op1_q};
            OP_ADD:  resultado_d = {{(WIDTH-1){1'b0}}, soma};
            OP_SUB:  resultado_d = {{(WIDTH-1){1'b0}}, dif};
            OP_MUL:  resultado_d = eng_produto;
            OP_DIV: begin
                if (op2_q == '0) begin
                    resultado_d = {op1_q, {WIDTH{1'b1}}};
                    div_zero_d  = 1'b1;
                end else begin
                    resultado_d = {eng_resto, eng_quo};
                end
            end
            OP_AND:  resultado_d = {{WIDTH{1'b0}}, op1_q & op2_q};
            OP_NAND: resultado_d = {{WIDTH{1'b0}}, ~(op1_q & op2_q)};
            OP_OR:   resultado_d = {{WIDTH{1'b0}}, op1_q | op2_q};
            OP_XOR:  resultado_d = {{WIDTH{1'b0}}, op1_q ^ op2_q};
            OP_NOT:  resultado_d = {{WIDTH{1'b0}}, ~op1_q};
            OP_CMP: begin
                if (a_maior)      resultado_d = {{(2*WIDTH-1){1'b0}}, 1'b1};
                else if (a_menor) resultado_d = '1;
            end
            OP_BEQ:  data_uc_d = zero1;
            OP_BGT:  data_uc_d = !neg1 && !zero1;
            OP_BLT:  data_uc_d = neg1;
            OP_BGE:  data_uc_d = !neg1;
            OP_BLE:  data_uc_d = neg1 || zero1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            opcode_q    <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            out_valid_q <= 1'b0;
            resultado_q <= '0;
            data_uc_q   <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                opcode_q <= bus.opcode;
                op1_q    <= bus.operando1;
                op2_q    <= bus.operando2;
            end
            if (captura) begin
                resultado_q <= resultado_d;
                data_uc_q   <= data_uc_d;
                div_zero_q  <= div_zero_d;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.resultado = resultado_q;
    assign bus.data_uc   = data_uc_q;
    assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_ula_sequencial.sv
// Directed self-checking bench for ula_sequencial at WIDTH=16.
module tb_ula_sequencial;
    import ula_pkg::*;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    ula_sequencial_if #(.WIDTH(W)) bus ();

    ula_sequencial #(.WIDTH(W)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, wait for the result, check it and consume it.
    task automatic run_op(input string tag, input logic [4:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] er, input logic euc,
                          input logic edz, input int elat);
        int   lat;
        logic ready_low;
        bus.opcode    = op;
        bus.operando1 = a;
        bus.operando2 = b;
        check({tag, "/in_ready"}, bus.in_ready, 1);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        // Inputs change after accept; the latched copy must be used.
        bus.opcode    = 5'b11111;
        bus.operando1 = ~a;
        bus.operando2 = ~b;
        lat       = 0;
        ready_low = 1'b1;
        do begin
            tick();
            lat++;
            if (bus.in_ready) ready_low = 1'b0;
        end while (!bus.out_valid && lat < 64);
        check({tag, "/out_valid"}, bus.out_valid, 1);
        check({tag, "/latency"}, lat, elat);
        check({tag, "/busy"}, ready_low, 1);
        check({tag, "/resultado"}, bus.resultado, er);
        check({tag, "/data_uc"}, bus.data_uc, euc);
        check({tag, "/div_zero"}, bus.div_zero, edz);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "/consumed"}, bus.out_valid, 0);
        check({tag, "/ready_again"}, bus.in_ready, 1);
        check({tag, "/kept"}, bus.resultado, er);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2*W-1:0] held;
        logic           stable;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.opcode    = '0;
        bus.operando1 = '0;
        bus.operando2 = '0;
        repeat (2) tick();
        rst = 1'b0;

        check("rst/in_ready", bus.in_ready, 1);
        check("rst/out_valid", bus.out_valid, 0);
        check("rst/resultado", bus.resultado, 0);
        check("rst/data_uc", bus.data_uc, 0);
        check("rst/div_zero", bus.div_zero, 0);

        run_op("add_carry",  OP_ADD,  16'hFFFF, 16'h0001, 32'h0001_0000, 0, 0, 1);
        run_op("sub_borrow", OP_SUB,  16'h0003, 16'h0005, 32'h0001_FFFE, 0, 0, 1);
        run_op("sub",        OP_SUB,  16'h0009, 16'h0004, 32'h0000_0005, 0, 0, 1);
        run_op("mov",        OP_MOV,  16'h1234, 16'hFFFF, 32'h0000_1234, 0, 0, 1);
        run_op("mul_max",    OP_MUL,  16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 0, 0, 17);
        run_op("mul",        OP_MUL,  16'd200,  16'd300,  32'h0000_EA60, 0, 0, 17);
        run_op("div",        OP_DIV,  16'd100,  16'd7,    {16'd2, 16'd14}, 0, 0, 17);
        run_op("div0",       OP_DIV,  16'd5,    16'd0,    {16'd5, 16'hFFFF}, 0, 1, 1);
        run_op("div_big",    OP_DIV,  16'hFFFF, 16'h0010, 32'h000F_0FFF, 0, 0, 17);
        run_op("and",        OP_AND,  16'hF0F0, 16'hFF00, 32'h0000_F000, 0, 0, 1);
        run_op("nand",       OP_NAND, 16'hF0F0, 16'hFF00, 32'h0000_0FFF, 0, 0, 1);
        run_op("or",         OP_OR,   16'hF0F0, 16'hFF00, 32'h0000_FFF0, 0, 0, 1);
        run_op("xor",        OP_XOR,  16'hF0F0, 16'hFF00, 32'h0000_0FF0, 0, 0, 1);
        run_op("not",        OP_NOT,  16'h00FF, 16'h1234, 32'h0000_FF00, 0, 0, 1);
        run_op("cmp_lt",     OP_CMP,  16'hFFFF, 16'h0001, 32'hFFFF_FFFF, 0, 0, 1);
        run_op("cmp_gt",     OP_CMP,  16'h0001, 16'hFFFF, 32'h0000_0001, 0, 0, 1);
        run_op("cmp_eq",     OP_CMP,  16'h8000, 16'h8000, 32'h0000_0000, 0, 0, 1);
        run_op("blt",        OP_BLT,  16'h8000, 16'h0000, 32'h0, 1, 0, 1);
        run_op("bgt_zero",   OP_BGT,  16'h0000, 16'h0000, 32'h0, 0, 0, 1);
        run_op("bgt",        OP_BGT,  16'h7FFF, 16'h0000, 32'h0, 1, 0, 1);
        run_op("beq",        OP_BEQ,  16'h0000, 16'h0000, 32'h0, 1, 0, 1);
        run_op("bge_neg",    OP_BGE,  16'h8001, 16'h0000, 32'h0, 0, 0, 1);
        run_op("ble_zero",   OP_BLE,  16'h0000, 16'h0000, 32'h0, 1, 0, 1);
        run_op("illegal",    5'b11111, 16'hFFFF, 16'hFFFF, 32'h0, 0, 0, 1);

        // Backpressure: result held while out_ready stays low, requests ignored.
        bus.opcode    = OP_ADD;
        bus.operando1 = 16'h0010;
        bus.operando2 = 16'h0020;
        bus.in_valid  = 1'b1;
        tick();
        bus.opcode    = OP_MOV;
        bus.operando1 = 16'hAAAA;
        tick();
        check("bp/out_valid", bus.out_valid, 1);
        held   = bus.resultado;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.resultado !== held || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
                stable = 1'b0;
        end
        check("bp/resultado", held, 32'h0000_0030);
        check("bp/stable", stable, 1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp/consumed", bus.out_valid, 0);
        check("bp/in_ready", bus.in_ready, 1);
        repeat (3) tick();
        check("bp/not_queued", bus.out_valid, 0);
        check("bp/kept", bus.resultado, 32'h0000_0030);

        // Reset during the eighth cycle of a multiply.
        bus.opcode    = OP_MUL;
        bus.operando1 = 16'h1234;
        bus.operando2 = 16'h5678;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (7) tick();
        check("rmul/busy", bus.in_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rmul/in_ready", bus.in_ready, 1);
        check("rmul/out_valid", bus.out_valid, 0);
        check("rmul/resultado", bus.resultado, 0);
        repeat (20) tick();
        check("rmul/discarded", bus.out_valid, 0);
        run_op("add_after_rst", OP_ADD, 16'd3, 16'd4, 32'd7, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
